// File: rtl/fb_pkg.sv
// Shared framebuffer arbiter definitions: default widths, screen size, read tags.
package fb_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 3;
  localparam int unsigned FB_WIDTH   = 160;
  localparam int unsigned FB_HEIGHT  = 120;
  localparam int unsigned STALL_W    = 16;

  // Owner of a RAM read travelling down the response pipeline.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_e;

  // Last host port served; the other one wins the next tie.
  typedef enum logic {
    HOST_WR = 1'b0,
    HOST_RD = 1'b1
  } host_e;

endpackage

// File: rtl/fb_rd_pipe.sv
// Read tag pipeline: follows each granted read through the RAM and routes the
// returned word to the display or host response register.
module fb_rd_pipe
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tag_e              tag_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_data_valid_o
);

  // Stage 1 lines up with the RAM command, stage 2 with the RAM read data.
  tag_e tag_s1_q, tag_s2_q;

  // Advance tags; reset drops every in-flight read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_s1_q <= TAG_NONE;
      tag_s2_q <= TAG_NONE;
    end else begin
      tag_s1_q <= tag_i;
      tag_s2_q <= tag_s1_q;
    end
  end

  // Register RAM data toward its owner; data holds when no read completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      disp_data_o     <= '0;
      disp_valid_o    <= 1'b0;
      rd_data_o       <= '0;
      rd_data_valid_o <= 1'b0;
    end else begin
      disp_valid_o    <= (tag_s2_q == TAG_DISP);
      rd_data_valid_o <= (tag_s2_q == TAG_HOST);
      if (tag_s2_q == TAG_DISP) disp_data_o <= ram_rdata_i;
      if (tag_s2_q == TAG_HOST) rd_data_o   <= ram_rdata_i;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display scanout has absolute priority,
// host read/write share the leftover cycles round-robin.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               disp_req_i,
  input  logic [ADDR_W-1:0]  disp_addr_i,
  output logic [DATA_W-1:0]  disp_data_o,
  output logic               disp_valid_o,
  input  logic               wr_valid_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  output logic               wr_ready_o,
  input  logic               rd_valid_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic               rd_ready_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               rd_data_valid_o,
  output logic               ram_en_o,
  output logic               ram_we_o,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic [DATA_W-1:0]  ram_wdata_o,
  input  logic [DATA_W-1:0]  ram_rdata_i,
  output logic [STALL_W-1:0] host_stall_cnt_o
);

  host_e last_host_q;
  tag_e  grant_tag;
  logic  stall_inc;

  // Grant decode: display first, then whichever host port was not served last.
  always_comb begin
    wr_ready_o = ~disp_req_i & wr_valid_i & (~rd_valid_i | (last_host_q == HOST_RD));
    rd_ready_o = ~disp_req_i & rd_valid_i & (~wr_valid_i | (last_host_q == HOST_WR));
    stall_inc  = (wr_valid_i & ~wr_ready_o) | (rd_valid_i & ~rd_ready_o);
    if (disp_req_i)      grant_tag = TAG_DISP;
    else if (rd_ready_o) grant_tag = TAG_HOST;
    else                 grant_tag = TAG_NONE;
  end

  // Register the granted RAM command; address/data hold when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else if (disp_req_i) begin
      ram_en_o   <= 1'b1;
      ram_we_o   <= 1'b0;
      ram_addr_o <= disp_addr_i;
    end else if (wr_ready_o) begin
      ram_en_o    <= 1'b1;
      ram_we_o    <= 1'b1;
      ram_addr_o  <= wr_addr_i;
      ram_wdata_o <= wr_data_i;
    end else if (rd_ready_o) begin
      ram_en_o   <= 1'b1;
      ram_we_o   <= 1'b0;
      ram_addr_o <= rd_addr_i;
    end else begin
      ram_en_o <= 1'b0;
      ram_we_o <= 1'b0;
    end
  end

  // Remember the last host port served; only real host grants move it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_host_q <= HOST_RD;
    end else if (wr_ready_o) begin
      last_host_q <= HOST_WR;
    end else if (rd_ready_o) begin
      last_host_q <= HOST_RD;
    end
  end

  // Saturating count of cycles a host request waited.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_stall_cnt_o <= '0;
    end else if (stall_inc && (host_stall_cnt_o != {STALL_W{1'b1}})) begin
      host_stall_cnt_o <= host_stall_cnt_o + 1'b1;
    end
  end

  fb_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tag_i          (grant_tag),
    .ram_rdata_i    (ram_rdata_i),
    .disp_data_o    (disp_data_o),
    .disp_valid_o   (disp_valid_o),
    .rd_data_o      (rd_data_o),
    .rd_data_valid_o(rd_data_valid_o)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a synchronous single-port RAM model.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [15:0]   stall_cnt;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  fb_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .disp_req_i      (disp_req),
    .disp_addr_i     (disp_addr),
    .disp_data_o     (disp_data),
    .disp_valid_o    (disp_valid),
    .wr_valid_i      (wr_valid),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .wr_ready_o      (wr_ready),
    .rd_valid_i      (rd_valid),
    .rd_addr_i       (rd_addr),
    .rd_ready_o      (rd_ready),
    .rd_data_o       (rd_data),
    .rd_data_valid_o (rd_data_valid),
    .ram_en_o        (ram_en),
    .ram_we_o        (ram_we),
    .ram_addr_o      (ram_addr),
    .ram_wdata_o     (ram_wdata),
    .ram_rdata_i     (ram_rdata),
    .host_stall_cnt_o(stall_cnt)
  );

  // RAM model: unwritten words read back as addr[2:0].
  logic [DW-1:0] wmem [int];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) wmem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= wmem.exists(int'(ram_addr)) ? wmem[int'(ram_addr)] : ram_addr[2:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req  = 1'b0;
    disp_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ram_en"}, 32'(ram_en), 0);
    chk({tag, " ram_we"}, 32'(ram_we), 0);
    chk({tag, " ram_addr"}, 32'(ram_addr), 0);
    chk({tag, " ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, " disp_valid"}, 32'(disp_valid), 0);
    chk({tag, " disp_data"}, 32'(disp_data), 0);
    chk({tag, " rd_data_valid"}, 32'(rd_data_valid), 0);
    chk({tag, " rd_data"}, 32'(rd_data), 0);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  // {disp_req, wr_valid, rd_valid, exp_wr_ready, exp_rd_ready}, applied right after reset.
  typedef struct packed {
    logic disp;
    logic wv;
    logic rv;
    logic exp_wr;
    logic exp_rd;
  } vec_t;
  vec_t vecs [12];

  initial begin
    vecs[0]  = 5'b000_00;
    vecs[1]  = 5'b111_00;
    vecs[2]  = 5'b011_10;  // reset state favours write
    vecs[3]  = 5'b011_01;
    vecs[4]  = 5'b001_01;
    vecs[5]  = 5'b001_01;
    vecs[6]  = 5'b011_10;
    vecs[7]  = 5'b010_10;
    vecs[8]  = 5'b011_01;
    vecs[9]  = 5'b101_00;
    vecs[10] = 5'b010_10;
    vecs[11] = 5'b110_00;

    idle();
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Grant table; rows 2,3,4,7,9,10,12 leave a host request waiting.
    for (int i = 0; i < 12; i++) begin
      disp_req = vecs[i].disp;
      wr_valid = vecs[i].wv;
      rd_valid = vecs[i].rv;
      wr_addr  = 15'h0100;
      wr_data  = 3'd0;
      rd_addr  = 15'h0200;
      @(negedge clk);
      chk($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d rd_ready", i), 32'(rd_ready), 32'(vecs[i].exp_rd));
      tick();
    end
    idle();
    @(negedge clk);
    chk("table stall_cnt", 32'(stall_cnt), 7);
    tick();

    // Display-only stream, addresses 0..3 back to back.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      disp_req  = (k < 4);
      disp_addr = AW'(k);
      @(negedge clk);
      chk($sformatf("disp c%0d valid", k), 32'(disp_valid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk($sformatf("disp c%0d data", k), 32'(disp_data), 32'(k - 3));
      if (k >= 7) chk($sformatf("disp c%0d hold", k), 32'(disp_data), 3);
      chk($sformatf("disp c%0d ram_en", k), 32'(ram_en), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk($sformatf("disp c%0d ram_addr", k), 32'(ram_addr), 32'(k - 1));
      tick();
    end

    // Full contention: display starves both host ports.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      disp_req  = 1'b1;
      disp_addr = 15'd6;
      wr_valid  = 1'b1;
      rd_valid  = 1'b1;
      @(negedge clk);
      chk($sformatf("contend c%0d wr_ready", k), 32'(wr_ready), 0);
      chk($sformatf("contend c%0d rd_ready", k), 32'(rd_ready), 0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("contend stall_cnt", 32'(stall_cnt), 4);
    tick();

    // Round-robin: W,R,W,R starting with write.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wr_valid = (k < 4);
      rd_valid = (k < 4);
      wr_addr  = 15'h0300;
      wr_data  = 3'd0;
      rd_addr  = 15'h0301;
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("rr c%0d wr_ready", k), 32'(wr_ready), 32'(k % 2 == 0));
        chk($sformatf("rr c%0d rd_ready", k), 32'(rd_ready), 32'(k % 2 == 1));
      end
      if (k > 0) begin
        chk($sformatf("rr c%0d ram_en", k), 32'(ram_en), 1);
        chk($sformatf("rr c%0d ram_we", k), 32'(ram_we), 32'((k - 1) % 2 == 0));
      end
      tick();
    end
    idle();

    // Write 0x1234 <= 5 then read it back.
    wr_valid = 1'b1;
    wr_addr  = 15'h1234;
    wr_data  = 3'b101;
    @(negedge clk);
    chk("coh wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = 15'h1234;
    @(negedge clk);
    chk("coh rd_ready", 32'(rd_ready), 1);
    tick();
    rd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("coh +%0d rd_data_valid", k), 32'(rd_data_valid), 32'(k == 3));
      if (k >= 3) chk($sformatf("coh +%0d rd_data", k), 32'(rd_data), 3'b101);
      tick();
    end

    // Reset while a host read is in flight.
    rd_valid = 1'b1;
    rd_addr  = 15'd5;
    @(negedge clk);
    chk("rstmid rd_ready", 32'(rd_ready), 1);
    tick();
    rd_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rstmid async ram_en", 32'(ram_en), 0);
    @(negedge clk);
    chk_all_zero("rstmid c1");
    tick();
    @(negedge clk);
    chk_all_zero("rstmid c2");
    tick();
    rst       = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 15'd7;
    @(negedge clk);
    chk("rstmid pre-grant ram_en", 32'(ram_en), 0);
    chk("rstmid c3 rd_data_valid", 32'(rd_data_valid), 0);
    tick();
    disp_req = 1'b0;
    @(negedge clk);
    chk("first grant ram_en", 32'(ram_en), 1);
    chk("first grant ram_addr", 32'(ram_addr), 7);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rstmid post%0d rd_data_valid", k), 32'(rd_data_valid), 0);
      tick();
      @(negedge clk);
    end

    // Stall counter saturation.
    do_reset();
    disp_req = 1'b1;
    rd_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat 65534", 32'(stall_cnt), 32'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    chk("sat 70000", 32'(stall_cnt), 32'hFFFF);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, framebuffer word address width (160x120 pixels).
REQ-002 Parameter DATA_W, default 3, pixel width (r, g, b bits).
REQ-003 clk_i  input  1  system clock, 50 MHz, single clock domain.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 disp_req_i  input  1  scanout read request; one-cycle pulse per pixel.
REQ-006 disp_addr_i  input  ADDR_W  scanout read address.
REQ-007 disp_data_o  output  DATA_W  scanout read data.
REQ-008 disp_valid_o  output  1  disp_data_o valid.
REQ-009 wr_valid_i, wr_addr_i[ADDR_W], wr_data_i[DATA_W]  input  host write request.
REQ-010 wr_ready_o  output  1  host write accepted this cycle.
REQ-011 rd_valid_i, rd_addr_i[ADDR_W]  input  host read request.
REQ-012 rd_ready_o  output  1  host read accepted this cycle.
REQ-013 rd_data_o[DATA_W], rd_data_valid_o[1]  output  host read response.
REQ-014 ram_en_o[1], ram_we_o[1], ram_addr_o[ADDR_W], ram_wdata_o[DATA_W]  output  single-port RAM command, registered.
REQ-015 ram_rdata_i  input  DATA_W  RAM read data, valid one cycle after ram_en_o with ram_we_o low.
REQ-016 host_stall_cnt_o  output  16  count of cycles a host request was pending but not accepted, saturating.

Function
REQ-017 At most one RAM access SHALL be granted per cycle.
REQ-018 Priority: disp_req_i SHALL always win; host ports SHALL be granted only in cycles with disp_req_i low.
REQ-019 Host read vs write: round-robin via 1-bit last_host flag; flag SHALL toggle only on an actual host grant; reset value favours write.
REQ-020 wr_ready_o and rd_ready_o SHALL be combinational from current-cycle requests and last_host; never both high; never high while disp_req_i high.
REQ-021 Transfer occurs on valid&ready; host SHALL hold valid, addr, data stable until accepted (bench checks).
REQ-022 Granted command SHALL appear on ram_* outputs the cycle after grant; ram_en_o low in cycles with no grant.
REQ-023 Read tags (display/host) SHALL be carried in a 2-stage pipeline; read data SHALL be registered onto disp_data_o or rd_data_o.
REQ-024 Latency: disp_valid_o (resp. rd_data_valid_o) SHALL assert exactly 3 cycles after the accepting cycle, for one cycle per read.
REQ-025 Back-to-back display requests every cycle SHALL be served at full rate (one valid per cycle, in order).
REQ-026 Writes SHALL produce no response; a host read following a write to the same address SHALL return the new data.
REQ-027 host_stall_cnt_o SHALL increment when (wr_valid_i & ~wr_ready_o) | (rd_valid_i & ~rd_ready_o), holding at 16'hFFFF.
REQ-028 disp_data_o and rd_data_o SHALL hold last value when not valid.

Reset
REQ-029 On rst_i high, immediately: ram_en_o, ram_we_o, disp_valid_o, rd_data_valid_o = 0; ram_addr_o, ram_wdata_o, disp_data_o, rd_data_o = 0; host_stall_cnt_o = 0; last_host = read (so write wins next).
REQ-030 Reset mid-operation SHALL discard in-flight reads; no valid pulse SHALL appear for requests accepted before reset.
REQ-031 First grant possible in the first clock edge after rst_i deasserts.

Structure
REQ-032 Shared package fb_pkg SHALL hold ADDR_W/DATA_W defaults, framebuffer dimensions (160, 120) and the tag encoding (TAG_NONE, TAG_DISP, TAG_HOST).
REQ-033 One sub-module, fb_rd_pipe, SHALL implement the tag pipeline and response routing; grant logic and stall counter stay in fb_arbiter.

Verification
REQ-034 Display only: disp_req_i pulses addr 0..3 consecutive cycles, RAM model returns addr[2:0] -> disp_valid_o cycles 3..6 with data 0,1,2,3.
REQ-035 Contention: disp_req_i, wr_valid_i, rd_valid_i all high 4 cycles -> wr_ready_o, rd_ready_o low throughout; host_stall_cnt_o = 4.
REQ-036 Round-robin: disp idle, wr and rd valid continuously -> grants alternate W,R,W,R starting with write.
REQ-037 Coherency: write addr 0x1234 data 3'b101, then read 0x1234 -> rd_data_o = 3'b101 three cycles after read accept.
REQ-038 Reset mid-flight: host read accepted, rst_i asserted next cycle for 2 cycles -> rd_data_valid_o never asserts; all outputs zero during reset.
REQ-039 Saturation: rd_valid_i held with disp_req_i high 70000 cycles -> host_stall_cnt_o = 16'hFFFF, no wrap.
